// File: rtl/eviction_sequencer_if.sv
// Handshake bundle between the miss sequencer, the pipeline miss port, the
// eviction policy and the memory-side writeback/refill channels.
interface eviction_sequencer_if #(
  parameter int unsigned NUM_WAYS  = 4,
  parameter int unsigned TAG_WIDTH = 20
);
  logic                 missValid;
  logic                 missReady;
  logic [TAG_WIDTH-1:0] missTag;
  logic [NUM_WAYS-1:0]  wayValid;
  logic [NUM_WAYS-1:0]  wayDirty;
  logic                 victimReq;
  logic                 evictionReady;
  logic [NUM_WAYS-1:0]  evictionTarget;
  logic                 wbValid;
  logic                 wbReady;
  logic [NUM_WAYS-1:0]  wbWay;
  logic                 fillValid;
  logic                 fillReady;
  logic [TAG_WIDTH-1:0] fillTag;
  logic                 fillDone;
  logic [NUM_WAYS-1:0]  allocateWay;
  logic                 missDone;
  logic                 missError;
  logic                 busy;

  // Sequencer side.
  modport slave (
    input  missValid, missTag, wayValid, wayDirty, evictionReady, evictionTarget,
           wbReady, fillReady, fillDone,
    output missReady, victimReq, wbValid, wbWay, fillValid, fillTag,
           allocateWay, missDone, missError, busy
  );

  // Pipeline / policy / memory side.
  modport master (
    output missValid, missTag, wayValid, wayDirty, evictionReady, evictionTarget,
           wbReady, fillReady, fillDone,
    input  missReady, victimReq, wbValid, wbWay, fillValid, fillTag,
           allocateWay, missDone, missError, busy
  );
endinterface

// File: rtl/eviction_sequencer.sv
// Miss-handling sequencer for one cache set: way selection, victim writeback,
// refill and allocate. Optional watchdog abort enabled by EVICT_TIMEOUT_EN.
module eviction_sequencer #(
  parameter int unsigned NUM_WAYS       = 4,
  parameter int unsigned TAG_WIDTH      = 20,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 reset,
  eviction_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT_VICTIM,
    S_WRITEBACK,
    S_REFILL,
    S_WAIT_FILL,
    S_ALLOCATE
  } state_e;

  state_e               state_q, state_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [NUM_WAYS-1:0]  way_q, way_d;
  logic [NUM_WAYS-1:0]  free_ways;
  logic [NUM_WAYS-1:0]  victim_pick;
  logic                 timeout_hit;

  function automatic logic [NUM_WAYS-1:0] lowest_one(input logic [NUM_WAYS-1:0] v);
    logic [NUM_WAYS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (v[i] && (r == '0)) r[i] = 1'b1;
    end
    return r;
  endfunction

  assign free_ways   = ~bus.wayValid;
  assign victim_pick = lowest_one(bus.evictionTarget);

`ifdef EVICT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;

  assign waiting     = (state_q == S_WAIT_VICTIM) || (state_q == S_WRITEBACK) ||
                       (state_q == S_REFILL)      || (state_q == S_WAIT_FILL);
  assign timeout_hit = waiting && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = '0;
    if (waiting && (state_d == state_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    way_d   = way_q;
    if (timeout_hit) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.missValid) begin
            tag_d   = bus.missTag;
            state_d = S_SELECT;
          end
        end
        S_SELECT: begin
          if (free_ways != '0) begin
            way_d   = lowest_one(free_ways);
            state_d = S_REFILL;
          end else begin
            state_d = S_WAIT_VICTIM;
          end
        end
        S_WAIT_VICTIM: begin
          // A ready policy with an empty target is not a usable answer.
          if (bus.evictionReady && (bus.evictionTarget != '0)) begin
            way_d   = victim_pick;
            state_d = ((bus.wayDirty & victim_pick) != '0) ? S_WRITEBACK : S_REFILL;
          end
        end
        S_WRITEBACK: if (bus.wbReady)   state_d = S_REFILL;
        S_REFILL:    if (bus.fillReady) state_d = S_WAIT_FILL;
        S_WAIT_FILL: if (bus.fillDone)  state_d = S_ALLOCATE;
        S_ALLOCATE:  state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      way_q   <= way_d;
    end
  end

  // Outputs decode registered state only; the abort cycle drops all requests.
  assign bus.missReady   = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.victimReq   = (state_q == S_WAIT_VICTIM) && !timeout_hit;
  assign bus.wbValid     = (state_q == S_WRITEBACK) && !timeout_hit;
  assign bus.wbWay       = bus.wbValid ? way_q : '0;
  assign bus.fillValid   = (state_q == S_REFILL) && !timeout_hit;
  assign bus.fillTag     = bus.fillValid ? tag_q : '0;
  assign bus.allocateWay = (state_q == S_ALLOCATE) ? way_q : '0;
  assign bus.missDone    = (state_q == S_ALLOCATE) || timeout_hit;
  assign bus.missError   = timeout_hit;

endmodule
